// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch buffer: issues sequential fetches to a variable-latency
// instruction memory over a req/ack handshake, queues {pc, instr} pairs in a
// small FIFO and presents the head to IF/ID with a valid/ready handshake.
// A taken-branch redirect flushes the FIFO and restarts fetching at the
// new target. An outstanding request is never withdrawn: if one is in flight
// when the redirect arrives, its response is drained and discarded first.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no request outstanding (FIFO full or just out of reset)
// ST_REQ   | imem_req=1, awaiting ack; the response is pushed
// ST_DRAIN | imem_req=1, awaiting ack; the response is dropped, then
//          | fetching resumes at the held redirect target
module instruction_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [63:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    input  logic                       fetch_ready,
    output logic                       fetch_valid,
    output logic [63:0]                fetch_pc,
    output logic [31:0]                fetch_instr,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [63:0]     npc_q,    npc_d;
    logic [63:0]     tgt_q,    tgt_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [63:0]     fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];

    logic            push;
    logic            pop;
    logic [63:0]     redirect_tgt;

    // Handshake qualifiers; a redirect suppresses any push or pop in its cycle.
    always_comb begin
        redirect_tgt = redirect_pc & ~64'h3;
        push         = (state_q == ST_REQ) && imem_ack && !redirect;
        pop          = (count_q != '0) && fetch_ready && !redirect;
    end

    // FIFO occupancy and pointer update; redirect empties the queue.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch sequencing: next state, next fetch address and held target.
    // IDLE looks at the post-pop occupancy so a single pop from a full FIFO
    // re-enables the request on the very next cycle.
    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    npc_d   = redirect_tgt;
                    state_d = ST_REQ;
                end else if (count_d < CNT_FULL) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        npc_d   = redirect_tgt;
                        state_d = ST_REQ;
                    end else begin
                        tgt_d   = redirect_tgt;
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    npc_d   = npc_q + 64'd4;
                    state_d = (count_d < CNT_FULL) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    // The response in flight belongs to the old path; the
                    // newest target wins when a redirect lands on the ack.
                    npc_d   = redirect ? redirect_tgt : tgt_q;
                    state_d = ST_REQ;
                end else if (redirect) begin
                    tgt_d   = redirect_tgt;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            npc_q    <= RESET_PC;
            tgt_q    <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            npc_q    <= npc_d;
            tgt_q    <= tgt_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage: write the returned instruction tagged with its fetch pc.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_q[wr_ptr_q]    <= npc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Outputs come straight from registers; head fields read as 0 when empty.
    always_comb begin
        imem_req    = (state_q != ST_IDLE);
        imem_addr   = npc_q;
        fetch_valid = (count_q != '0);
        buf_count   = count_q;
        fetch_pc    = fetch_valid ? fifo_pc_q[rd_ptr_q]    : 64'h0;
        fetch_instr = fetch_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Randomized bench for instruction_fetch_buffer against a queue-based model.
module tb_instruction_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [63:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [63:0]   fetch_pc;
    logic [31:0]   fetch_instr;
    logic [CW-1:0] buf_count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: what has been fetched and not yet consumed, plus
    // whether a memory request is in flight and whether its answer is stale.
    logic [63:0] mdl_pcq [$];
    logic [31:0] mdl_inq [$];
    bit          mdl_req;
    bit          mdl_drop;
    logic [63:0] mdl_npc;
    logic [63:0] mdl_tgt;

    instruction_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .buf_count   (buf_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_pcq.delete();
        mdl_inq.delete();
        mdl_req  = 1'b0;
        mdl_drop = 1'b0;
        mdl_npc  = RESET_PC;
        mdl_tgt  = RESET_PC;
    endtask

    task automatic check_outputs();
        int sz;
        sz = mdl_pcq.size();
        chk("imem_req",    {63'd0, imem_req},    {63'd0, mdl_req});
        chk("imem_addr",   imem_addr,            mdl_npc);
        chk("fetch_valid", {63'd0, fetch_valid}, {63'd0, sz != 0});
        chk("buf_count",   64'(buf_count),       64'(sz));
        chk("fetch_pc",    fetch_pc,             (sz != 0) ? mdl_pcq[0] : 64'h0);
        chk("fetch_instr", {32'd0, fetch_instr}, {32'd0, (sz != 0) ? mdl_inq[0] : 32'h0});
    endtask

    // Advance the model by one clock using the inputs that were applied.
    task automatic model_step();
        logic [63:0] rpc;
        rpc = redirect_pc & ~64'h3;
        if (redirect) begin
            mdl_pcq.delete();
            mdl_inq.delete();
            if (!mdl_req || imem_ack) begin
                mdl_npc  = rpc;
                mdl_req  = 1'b1;
                mdl_drop = 1'b0;
            end else begin
                mdl_tgt  = rpc;
                mdl_drop = 1'b1;
            end
        end else begin
            if (mdl_pcq.size() != 0 && fetch_ready) begin
                void'(mdl_pcq.pop_front());
                void'(mdl_inq.pop_front());
            end
            if (!mdl_req) begin
                if (mdl_pcq.size() < DEPTH) mdl_req = 1'b1;
            end else if (imem_ack) begin
                if (mdl_drop) begin
                    mdl_npc  = mdl_tgt;
                    mdl_drop = 1'b0;
                end else begin
                    chk("room_on_ack", 64'(mdl_pcq.size() < DEPTH), 64'd1);
                    mdl_pcq.push_back(mdl_npc);
                    mdl_inq.push_back(mem_word(mdl_npc));
                    mdl_npc = mdl_npc + 64'd4;
                    if (mdl_pcq.size() >= DEPTH) mdl_req = 1'b0;
                end
            end
        end
    endtask

    // One cycle: check at the negedge, drive new inputs, step at the posedge.
    task automatic do_cycle(input int ack_pct, input int rdy_pct, input int red_pct);
        check_outputs();
        imem_ack    = ($urandom_range(99) < ack_pct);
        imem_rdata  = (imem_ack && imem_req) ? mem_word(imem_addr) : $urandom();
        fetch_ready = ($urandom_range(99) < rdy_pct);
        redirect    = ($urandom_range(99) < red_pct);
        case ($urandom_range(3))
            0:       redirect_pc = {$urandom(), $urandom()};
            1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
            default: redirect_pc = 64'($urandom_range(16'hFFFF));
        endcase
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic run_phase(input int n, input int ack_pct, input int rdy_pct, input int red_pct);
        for (int i = 0; i < n; i++) do_cycle(ack_pct, rdy_pct, red_pct);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_outputs();
        reset = 1'b1;
    endtask

    initial begin
        bit saw_req;
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        fetch_ready = 1'b0;
        @(negedge clock);
        apply_reset();

        run_phase(40,  100, 100, 0);
        run_phase(30,  100, 0,   0);
        run_phase(30,  100, 30,  0);
        run_phase(200, 30,  70,  5);
        run_phase(200, 100, 100, 10);
        run_phase(200, 50,  50,  10);
        run_phase(200, 20,  90,  25);

        // Asynchronous reset while a request is outstanding.
        saw_req = 1'b0;
        for (int i = 0; i < 50 && !saw_req; i++) begin
            if (imem_req) saw_req = 1'b1;
            else do_cycle(0, 0, 0);
        end
        chk("req_before_async_rst", {63'd0, saw_req}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req",   {63'd0, imem_req},    64'd0);
        chk("arst_valid", {63'd0, fetch_valid}, 64'd0);
        chk("arst_addr",  imem_addr,            RESET_PC);
        chk("arst_count", 64'(buf_count),       64'd0);
        chk("arst_pc",    fetch_pc,             64'd0);
        chk("arst_instr", {32'd0, fetch_instr}, 64'd0);
        model_reset();
        @(negedge clock);
        apply_reset();

        run_phase(200, 60, 60, 8);
        run_phase(100, 100, 100, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
